// File: rtl/seg7_scan_mux.sv
// Multiplexed seven-segment driver: scans NUM_DIGITS digits, one per REFRESH_DIV clocks,
// with a per-frame input snapshot, optional hex decode and leading-zero blanking.
module seg7_scan_mux #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 65536,
    parameter int HEX_EN      = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] nums,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_lz,
    output logic [6:0]              display,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   digit,
    output logic                    frame_done
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    typedef enum logic {ST_IDLE, ST_SCAN} state_t;

    logic [CW-1:0]           cnt_q, cnt_d;
    state_t                  state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] sh_nums_q, sh_nums_d;
    logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d;
    logic                    sh_blank_q, sh_blank_d;
    logic [6:0]              display_q, display_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   digit_q, digit_d;
    logic                    frame_done_q, frame_done_d;

    logic       tick;
    logic       capture;
    logic [3:0] nibble;
    logic       upper_zero;
    logic       blank;

    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        logic [6:0] seg;
        case (n)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = (HEX_EN != 0) ? 7'b0001000 : 7'b1111111;
            4'hB:    seg = (HEX_EN != 0) ? 7'b0000011 : 7'b1111111;
            4'hC:    seg = (HEX_EN != 0) ? 7'b1000110 : 7'b1111111;
            4'hD:    seg = (HEX_EN != 0) ? 7'b0100001 : 7'b1111111;
            4'hE:    seg = (HEX_EN != 0) ? 7'b0000110 : 7'b1111111;
            default: seg = (HEX_EN != 0) ? 7'b0001110 : 7'b1111111;
        endcase
        return seg;
    endfunction

    // Snapshot is taken on every tick that lands in SCAN(0), so a whole frame sees one input set.
    always_comb begin
        tick         = (cnt_q == CNT_LAST);
        cnt_d        = tick ? '0 : cnt_q + 1'b1;
        state_d      = state_q;
        idx_d        = idx_q;
        capture      = 1'b0;
        frame_done_d = 1'b0;
        if (tick) begin
            if (state_q == ST_IDLE) begin
                state_d = ST_SCAN;
                idx_d   = '0;
                capture = 1'b1;
            end else if (idx_q == IDX_LAST) begin
                idx_d        = '0;
                capture      = 1'b1;
                frame_done_d = 1'b1;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
        sh_nums_d  = capture ? nums     : sh_nums_q;
        sh_dp_d    = capture ? dp_in    : sh_dp_q;
        sh_blank_d = capture ? blank_lz : sh_blank_q;
    end

    // Outputs are decoded from next-state values so they change on the same edge as the scan.
    always_comb begin
        nibble     = sh_nums_d[4*int'(idx_d) +: 4];
        upper_zero = 1'b1;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if (j >= int'(idx_d) && sh_nums_d[4*j +: 4] != 4'd0) begin
                upper_zero = 1'b0;
            end
        end
        blank = sh_blank_d && (idx_d != '0) && upper_zero;
        if (state_d == ST_IDLE) begin
            display_d = 7'b1111111;
            dp_d      = 1'b1;
            digit_d   = '1;
        end else begin
            digit_d   = ~(NUM_DIGITS'(1) << idx_d);
            dp_d      = ~sh_dp_d[idx_d];
            display_d = blank ? 7'b1111111 : seg_decode(nibble);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            sh_nums_q    <= '0;
            sh_dp_q      <= '0;
            sh_blank_q   <= 1'b0;
            display_q    <= 7'b1111111;
            dp_q         <= 1'b1;
            digit_q      <= '1;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            state_q      <= state_d;
            idx_q        <= idx_d;
            sh_nums_q    <= sh_nums_d;
            sh_dp_q      <= sh_dp_d;
            sh_blank_q   <= sh_blank_d;
            display_q    <= display_d;
            dp_q         <= dp_d;
            digit_q      <= digit_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign display    = display_q;
    assign dp         = dp_q;
    assign digit      = digit_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Self-checking bench for seg7_scan_mux: directed scenarios plus randomized inputs,
// compared every cycle against a timing model derived from edges-since-reset arithmetic.
module tb_seg7_scan_mux;

    localparam int N  = 4;
    localparam int RD = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [4*N-1:0] nums;
    logic [N-1:0]   dp_in;
    logic           blank_lz;

    logic [6:0]     display_hex, display_nohex;
    logic           dp_hex, dp_nohex;
    logic [N-1:0]   digit_hex, digit_nohex;
    logic           fd_hex, fd_nohex;

    int checks   = 0;
    int failures = 0;

    // Model state: edges since reset release and the inputs latched at each frame start.
    int             m_edges = 0;
    logic [4*N-1:0] m_nums  = '0;
    logic [N-1:0]   m_dp    = '0;
    logic           m_blank = 1'b0;

    always #5 clk = ~clk;

    seg7_scan_mux #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .HEX_EN(1)) dut_hex (
        .clk(clk), .rst(rst), .nums(nums), .dp_in(dp_in), .blank_lz(blank_lz),
        .display(display_hex), .dp(dp_hex), .digit(digit_hex), .frame_done(fd_hex)
    );

    seg7_scan_mux #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .HEX_EN(0)) dut_nohex (
        .clk(clk), .rst(rst), .nums(nums), .dp_in(dp_in), .blank_lz(blank_lz),
        .display(display_nohex), .dp(dp_nohex), .digit(digit_nohex), .frame_done(fd_nohex)
    );

    // A new frame begins on edge RD after release and then every RD*N edges.
    always @(posedge clk) begin
        if (rst) begin
            m_edges <= 0;
            m_nums  <= '0;
            m_dp    <= '0;
            m_blank <= 1'b0;
        end else begin
            if (m_edges + 1 >= RD && ((m_edges + 1 - RD) % (RD * N)) == 0) begin
                m_nums  <= nums;
                m_dp    <= dp_in;
                m_blank <= blank_lz;
            end
            m_edges <= m_edges + 1;
        end
    end

    function automatic int expIdx();
        if (m_edges < RD) return -1;
        return ((m_edges - RD) / RD) % N;
    endfunction

    function automatic logic [6:0] segOf(input int n, input bit hex);
        case (n)
            0:  return 7'b1000000;
            1:  return 7'b1111001;
            2:  return 7'b0100100;
            3:  return 7'b0110000;
            4:  return 7'b0011001;
            5:  return 7'b0010010;
            6:  return 7'b0000010;
            7:  return 7'b1111000;
            8:  return 7'b0000000;
            9:  return 7'b0010000;
            10: return hex ? 7'b0001000 : 7'b1111111;
            11: return hex ? 7'b0000011 : 7'b1111111;
            12: return hex ? 7'b1000110 : 7'b1111111;
            13: return hex ? 7'b0100001 : 7'b1111111;
            14: return hex ? 7'b0000110 : 7'b1111111;
            default: return hex ? 7'b0001110 : 7'b1111111;
        endcase
    endfunction

    function automatic logic [6:0] expDisplay(input bit hex);
        int i;
        int value;
        i = expIdx();
        if (i < 0) return 7'b1111111;
        value = int'(m_nums);
        if (m_blank && i > 0 && (value >> (4 * i)) == 0) return 7'b1111111;
        return segOf((value >> (4 * i)) % 16, hex);
    endfunction

    function automatic logic [N-1:0] expDigit();
        int i;
        i = expIdx();
        if (i < 0) return '1;
        return ~(N'(1) << i);
    endfunction

    function automatic logic expDp();
        int i;
        i = expIdx();
        if (i < 0) return 1'b1;
        return ~m_dp[i];
    endfunction

    function automatic logic expFrameDone();
        return (m_edges >= RD + RD * N) && (((m_edges - RD) % (RD * N)) == 0);
    endfunction

    task automatic checkOne(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, m_edges);
        end
    endtask

    task automatic checkOutput();
        checkOne("digit",         32'(digit_hex),     32'(expDigit()));
        checkOne("display",       32'(display_hex),   32'(expDisplay(1'b1)));
        checkOne("dp",            32'(dp_hex),        32'(expDp()));
        checkOne("frame_done",    32'(fd_hex),        32'(expFrameDone()));
        checkOne("display_nohex", 32'(display_nohex), 32'(expDisplay(1'b0)));
        checkOne("digit_nohex",   32'(digit_nohex),   32'(expDigit()));
        if (fd_hex === 1'b1) checkOne("fd_not_idle", 32'(digit_hex == '1), 32'd0);
    endtask

    task automatic runCycles(input int n);
        repeat (n) begin
            @(negedge clk);
            checkOutput();
        end
    endtask

    task automatic applyStimulus(input logic [4*N-1:0] n, input logic [N-1:0] d, input logic b);
        nums     = n;
        dp_in    = d;
        blank_lz = b;
    endtask

    task automatic doReset();
        rst = 1'b1;
        runCycles(2);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus('0, '0, 1'b0);
        runCycles(3);
        checkOne("reset_digit",   32'(digit_hex),   32'h0000000F);
        checkOne("reset_display", 32'(display_hex), 32'h0000007F);
        checkOne("reset_dp",      32'(dp_hex),      32'd1);
        checkOne("reset_fd",      32'(fd_hex),      32'd0);

        $display("[TB] scan 1234");
        applyStimulus(16'h1234, 4'b0000, 1'b0);
        rst = 1'b0;
        runCycles(3);
        checkOne("pre_tick_digit", 32'(digit_hex), 32'h0000000F);
        runCycles(1);
        checkOne("first_scan_digit",   32'(digit_hex),   32'h0000000E);
        checkOne("first_scan_display", 32'(display_hex), 32'(7'b0011001));
        runCycles(12);
        checkOne("scan3_digit",   32'(digit_hex),   32'h00000007);
        checkOne("scan3_display", 32'(display_hex), 32'(7'b1111001));
        runCycles(20);

        $display("[TB] blanking 00A0");
        applyStimulus(16'h00A0, 4'b0000, 1'b1);
        doReset();
        runCycles(8);
        checkOne("a0_digit1_hex",   32'(display_hex),   32'(7'b0001000));
        checkOne("a0_digit1_nohex", 32'(display_nohex), 32'(7'b1111111));
        runCycles(16);

        $display("[TB] all zero with dp");
        applyStimulus(16'h0000, 4'b0100, 1'b1);
        doReset();
        runCycles(4);
        checkOne("zero_digit0", 32'(display_hex), 32'(7'b1000000));
        runCycles(8);
        checkOne("zero_dp2",    32'(dp_hex),      32'd0);
        checkOne("zero_blank2", 32'(display_hex), 32'(7'b1111111));
        runCycles(12);

        $display("[TB] mid-frame input change");
        applyStimulus(16'h1111, 4'b0000, 1'b0);
        doReset();
        runCycles(9);
        applyStimulus(16'h2222, 4'b0000, 1'b0);
        runCycles(7);
        checkOne("old_frame_digit3", 32'(display_hex), 32'(7'b1111001));
        runCycles(4);
        checkOne("new_frame_digit0", 32'(display_hex), 32'(7'b0100100));
        runCycles(8);

        $display("[TB] reset during SCAN(2)");
        applyStimulus(16'h5678, 4'b1111, 1'b0);
        doReset();
        runCycles(13);
        checkOne("before_rst_digit", 32'(digit_hex), 32'h0000000B);
        rst = 1'b1;
        runCycles(1);
        checkOne("rst_digit",   32'(digit_hex),   32'h0000000F);
        checkOne("rst_display", 32'(display_hex), 32'h0000007F);
        checkOne("rst_dp",      32'(dp_hex),      32'd1);
        rst = 1'b0;
        runCycles(3);
        checkOne("rst_release_idle", 32'(digit_hex), 32'h0000000F);
        runCycles(1);
        checkOne("rst_release_scan0", 32'(digit_hex), 32'h0000000E);

        $display("[TB] randomized run");
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            checkOutput();
            if ($urandom_range(0, 3) == 0) begin
                logic [4*N-1:0] mask;
                case ($urandom_range(0, 3))
                    0: mask = 16'h000F;
                    1: mask = 16'h00F0;
                    2: mask = 16'h0FFF;
                    default: mask = 16'hFFFF;
                endcase
                applyStimulus(16'($urandom) & mask, 4'($urandom), 1'($urandom));
            end
            rst = ($urandom_range(0, 149) == 0);
        end
        rst = 1'b0;
        runCycles(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg7_scan_mux.md
SEG7_SCAN_MUX -- requirements
Module: seg7_scan_mux

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of multiplexed digits; legal range 1..8.
REQ-002 Parameter REFRESH_DIV, default 65536, clk cycles each digit stays lit; legal range >= 2.
REQ-003 Parameter HEX_EN, default 1, 1 = decode nibbles 10-15 as A-F; 0 = blank them.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 nums  input  4*NUM_DIGITS  one nibble per digit; digit i = nums[4i+3:4i]; digit 0 is least significant.
REQ-007 dp_in  input  NUM_DIGITS  decimal point request per digit, active-high.
REQ-008 blank_lz  input  1  leading-zero suppression enable.
REQ-009 display  output  7  segments gfedcba, active-low, registered.
REQ-010 dp  output  1  decimal point, active-low, registered.
REQ-011 digit  output  NUM_DIGITS  digit enables, active-low, at most one bit low, registered.
REQ-012 frame_done  output  1  one-cycle pulse at end of each complete scan frame.

Function
REQ-013 Prescaler shall count 0..REFRESH_DIV-1 and wrap; "tick" = cycle where count equals REFRESH_DIV-1.
REQ-014 Scan state shall be IDLE after reset, then SCAN(i), i = 0..NUM_DIGITS-1.
REQ-015 On a tick: IDLE -> SCAN(0); SCAN(i) -> SCAN(i+1); SCAN(NUM_DIGITS-1) -> SCAN(0); no state change without a tick.
REQ-016 On every tick entering SCAN(0), nums, dp_in and blank_lz shall be captured into shadow registers.
REQ-017 All outputs for one frame shall come from the shadow registers; input changes mid-frame shall not affect the frame.
REQ-018 In SCAN(i), digit shall have only bit i low.
REQ-019 In SCAN(i), dp shall be the inverse of shadow dp_in[i].
REQ-020 Decode, active-low gfedcba: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-021 If HEX_EN=1, decode A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-022 If HEX_EN=0, nibbles 10-15 shall drive display 1111111.
REQ-023 Leading-zero blanking: digit i (i>0) shall be blanked when shadow blank_lz=1 and shadow nibbles i..NUM_DIGITS-1 are all zero.
REQ-024 Digit 0 shall never be blanked; all-zero input shows a single "0".
REQ-025 A blanked digit shall drive display 1111111, while digit and dp still follow REQ-018/019.
REQ-026 Outputs shall update on the same clk edge as the state transition; latency from tick to new pattern is one edge.
REQ-027 frame_done shall pulse high for exactly one cycle on the edge of the SCAN(NUM_DIGITS-1) -> SCAN(0) transition; it shall not pulse on IDLE -> SCAN(0).
REQ-028 For NUM_DIGITS=1, every tick after the first shall be a SCAN(0) -> SCAN(0) transition with frame_done and shadow capture.

Reset
REQ-029 While rst=1: prescaler=0, state=IDLE, shadows=0, display=1111111, dp=1, digit=all ones, frame_done=0.
REQ-030 rst asserted mid-frame shall take effect on the next edge, overriding any tick on that cycle.
REQ-031 After rst deasserts, the first tick and SCAN(0) shall occur on the REFRESH_DIV-th rising edge.

Verification (NUM_DIGITS=4, REFRESH_DIV=4, HEX_EN=1 unless stated)
REQ-032 Scenario: nums=16'h1234, dp_in=0, blank_lz=0 -> digit sequence 1110,1101,1011,0111, each held 4 cycles; display 0011001,0110000,0100100,1111001.
REQ-033 Scenario: nums=16'h00A0, blank_lz=1 -> digit 0 shows 1000000, digit 1 shows 0001000, digits 2-3 show 1111111; with HEX_EN=0, digit 1 shows 1111111.
REQ-034 Scenario: nums=16'h0000, blank_lz=1, dp_in=4'b0100 -> only digit 0 shows "0"; dp=0 only while digit=1011.
REQ-035 Scenario: change nums from 16'h1111 to 16'h2222 during SCAN(1) -> digits 1-3 of that frame still show "1"; the next frame shows "2".
REQ-036 Scenario: count edges -> frame_done high for 1 cycle every 16 cycles, first pulse 16 cycles after first SCAN(0); never high with digit=1111.
REQ-037 Scenario: assert rst during SCAN(2) -> next edge gives digit=1111, display=1111111, dp=1; SCAN(0) returns 4 edges after release.
